// File: rtl/uart_pkg.sv
// Shared UART transmit types and constants: state encoding, data width, default bit period.
package uart_pkg;

  localparam int unsigned UART_DATA_W           = 8;
  localparam int unsigned UART_STATE_W          = 3;
  localparam int unsigned UART_CLKS_PER_BIT_DEF = 5000;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

  typedef enum logic [UART_STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Even parity over the byte, inverted when odd parity is selected.
  function automatic logic uart_parity(input uart_byte_t d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte source <-> UART transmitter handshake plus serial line and status.
interface uart_tx_ctrl_if;
  import uart_pkg::*;

  uart_byte_t tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       txd;
  logic       busy;
  logic       tx_done;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, txd, busy, tx_done
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, txd, busy, tx_done
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = uart_pkg::UART_CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || (cnt_q == CNT_MAX)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tick = (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, 8 data bits LSB-first, optional parity, stop bit(s).
// Define UART_TX_PARITY_EN to insert a parity bit after data bit 7.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_tx_ctrl_if.slave bus
);

  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  if ((CLKS_PER_BIT < 2) || (STOP_BITS < 1) || (STOP_BITS > 2) || (PARITY_ODD > 1)) begin : g_bad_param
    $error("uart_tx_ctrl: illegal parameter value");
  end

  uart_state_e state_q, state_d;
  uart_byte_t  shift_q, shift_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        stop_cnt_q, stop_cnt_d;
  logic        txd_q, txd_d;
  logic        done_c;
  logic        accept_c;
  logic        bit_tick;
`ifdef UART_TX_PARITY_EN
  logic        parity_q;
`endif

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_q == ST_IDLE),
    .tick (bit_tick)
  );

  assign accept_c = bus.tx_valid && (state_q == ST_IDLE);

  // Next-state, datapath and next line level; txd is registered from the next state.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    done_c     = 1'b0;
    txd_d      = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d = ST_START;
          shift_d = bus.tx_data;
        end
      end
      ST_START: begin
        if (bit_tick) begin
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
            stop_cnt_d = 1'b0;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_tick) begin
          state_d    = ST_STOP;
          stop_cnt_d = 1'b0;
        end
      end
`endif
      ST_STOP: begin
        if (bit_tick) begin
          if (stop_cnt_q == STOP_LAST) begin
            state_d = ST_IDLE;
            done_c  = 1'b1;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd_d = parity_q;
`endif
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      txd_q      <= txd_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity is fixed at accept so later tx_data changes cannot alter it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else if (accept_c) begin
      parity_q <= uart_parity(bus.tx_data, 1'(PARITY_ODD));
    end
  end
`endif

  assign bus.txd      = txd_q;
  assign bus.tx_ready = (state_q == ST_IDLE);
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.tx_done  = done_c;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: table vectors, hand sequences and random frames vs a bit-list model.
module tb_uart_tx_ctrl;

  localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] din [3];
  logic       vin [3];
  logic       txd_o [3];
  logic       ready_o [3];
  logic       busy_o [3];
  logic       done_o [3];

  uart_tx_ctrl_if u_if0();
  uart_tx_ctrl_if u_if1();
  uart_tx_ctrl_if u_if2();

  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(u_if0));
  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(u_if1));
  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(1)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(u_if2));

  assign u_if0.tx_data = din[0];
  assign u_if0.tx_valid = vin[0];
  assign u_if1.tx_data = din[1];
  assign u_if1.tx_valid = vin[1];
  assign u_if2.tx_data = din[2];
  assign u_if2.tx_valid = vin[2];

  assign txd_o[0] = u_if0.txd;
  assign txd_o[1] = u_if1.txd;
  assign txd_o[2] = u_if2.txd;
  assign ready_o[0] = u_if0.tx_ready;
  assign ready_o[1] = u_if1.tx_ready;
  assign ready_o[2] = u_if2.tx_ready;
  assign busy_o[0] = u_if0.busy;
  assign busy_o[1] = u_if1.busy;
  assign busy_o[2] = u_if2.busy;
  assign done_o[0] = u_if0.tx_done;
  assign done_o[1] = u_if1.tx_done;
  assign done_o[2] = u_if2.tx_done;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: list of line levels, one entry per clock cycle of the frame.
  logic exp_q[$];

  task automatic model_frame(input int sel, input logic [7:0] d);
    logic bits[$];
    int   nstop;
    logic podd;
    nstop = (sel == 1) ? 2 : 1;
    podd  = (sel == 2);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (P == 1) bits.push_back((^d) ^ podd);
    for (int s = 0; s < nstop; s++) bits.push_back(1'b1);
    exp_q.delete();
    foreach (bits[b])
      for (int c = 0; c < int'(CPB); c++) exp_q.push_back(bits[b]);
  endtask

  task automatic run_frame(input int sel, input logic [7:0] d, input int exp_len,
                           input bit keep_valid, input int chg_at, input logic [7:0] chg_d);
    model_frame(sel, d);
    chk($sformatf("ready_pre u%0d 0x%02h", sel, d), ready_o[sel], 1);
    din[sel] = d;
    vin[sel] = 1'b1;
    step();
    if (!keep_valid) vin[sel] = 1'b0;
    for (int k = 1; k <= exp_len; k++) begin
      chk($sformatf("txd u%0d 0x%02h c%0d", sel, d, k), txd_o[sel],
          (k <= exp_q.size()) ? exp_q[k-1] : 1'b1);
      chk($sformatf("tx_done u%0d 0x%02h c%0d", sel, d, k), done_o[sel], (k == exp_len));
      chk($sformatf("busy u%0d c%0d", sel, k), busy_o[sel], 1);
      chk($sformatf("tx_ready u%0d c%0d", sel, k), ready_o[sel], 0);
      if (k == chg_at) din[sel] = chg_d;
      step();
    end
    chk($sformatf("ready_post u%0d 0x%02h", sel, d), ready_o[sel], 1);
    chk($sformatf("busy_post u%0d", sel), busy_o[sel], 0);
    chk($sformatf("txd_post u%0d", sel), txd_o[sel], 1);
    chk($sformatf("done_post u%0d", sel), done_o[sel], 0);
  endtask

  typedef struct {
    int         sel;
    logic [7:0] data;
    int         exp_len;
  } vec_t;

  vec_t tbl[7];

  initial begin
    for (int s = 0; s < 3; s++) begin
      din[s] = 8'h00;
      vin[s] = 1'b0;
    end
    tbl[0] = '{0, 8'hA5, 40 + 4*P};
    tbl[1] = '{1, 8'h81, 44 + 4*P};
    tbl[2] = '{0, 8'h07, 40 + 4*P};
    tbl[3] = '{0, 8'h03, 40 + 4*P};
    tbl[4] = '{2, 8'h07, 40 + 4*P};
    tbl[5] = '{2, 8'h03, 40 + 4*P};
    tbl[6] = '{1, 8'h00, 44 + 4*P};

    // Reset state, then idle with tx_valid low
    #12;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("rst txd u%0d", s), txd_o[s], 1);
      chk($sformatf("rst ready u%0d", s), ready_o[s], 1);
      chk($sformatf("rst busy u%0d", s), busy_o[s], 0);
      chk($sformatf("rst done u%0d", s), done_o[s], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      step();
      for (int s = 0; s < 3; s++) begin
        chk($sformatf("idle txd u%0d", s), txd_o[s], 1);
        chk($sformatf("idle ready u%0d", s), ready_o[s], 1);
        chk($sformatf("idle busy u%0d", s), busy_o[s], 0);
      end
    end

    // Table vectors
    for (int i = 0; i < 7; i++) begin
      run_frame(tbl[i].sel, tbl[i].data, tbl[i].exp_len, 1'b0, 0, 8'h00);
      step();
    end

    // Back-to-back with tx_valid held high; tx_data changes mid-frame
    run_frame(0, 8'h00, 40 + 4*P, 1'b1, 20, 8'hFF);
    run_frame(0, 8'hFF, 40 + 4*P, 1'b0, 0, 8'h00);
    step();

    // Reset during DATA bit 3
    din[0] = 8'h00;
    vin[0] = 1'b1;
    step();
    vin[0] = 1'b0;
    repeat (17) step();
    chk("pre_abort txd", txd_o[0], 0);
    chk("pre_abort busy", busy_o[0], 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort txd", txd_o[0], 1);
    chk("abort busy", busy_o[0], 0);
    chk("abort ready", ready_o[0], 1);
    chk("abort done", done_o[0], 0);
    repeat (2) begin
      step();
      chk("abort hold txd", txd_o[0], 1);
      chk("abort hold done", done_o[0], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_frame(0, 8'h3C, 40 + 4*P, 1'b0, 0, 8'h00);

    // Random frames against the model
    for (int r = 0; r < 24; r++) begin
      int         sel;
      int         gap;
      logic [7:0] d;
      sel = int'($urandom_range(0, 2));
      gap = int'($urandom_range(0, 3));
      d   = 8'($urandom);
      for (int g = 0; g < gap; g++) begin
        chk($sformatf("gap txd u%0d", sel), txd_o[sel], 1);
        chk($sformatf("gap ready u%0d", sel), ready_o[sel], 1);
        step();
      end
      run_frame(sel, d, (9 + P + ((sel == 1) ? 2 : 1)) * int'(CPB), 1'b0, 0, 8'h00);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
